fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Drain stage sitting directly downstream of the team's sync FIFO: pops words from the FIFO and
//  serialises each as an asynchronous UART frame (start, LSB-first data, optional parity, stop).
//  Absorbs the FIFO's 1-cycle registered read latency; the FIFO is the only data source.
// PARAMETERS
//  DATA_WIDTH  8   data bits per frame; equals FIFO DATA_WIDTH
//  CLK_DIV     16  clk cycles per bit period, >=2
//  PARITY_EN   0   1: append even-parity bit after data
//  STOP_BITS   1   stop bits per frame, 1 or 2
// PORTS
//  clk         in   1           clock
//  rst_n       in   1           reset, asynchronous, active-low
//  enable      in   1           1: permit popping new words
//  fifo_empty  in   1           FIFO empty flag
//  fifo_rd_en  out  1           FIFO pop strobe, 1-cycle pulse
//  fifo_data   in   DATA_WIDTH  FIFO data_o, valid the cycle after fifo_rd_en
//  tx          out  1           serial line, idle high
//  busy        out  1           1 whenever state != IDLE
//  frame_done  out  1           1-cycle pulse in last cycle of final stop bit
// BEHAVIOUR
//  - Reset: state IDLE; tx=1, fifo_rd_en=0, busy=0, frame_done=0; shift reg, baud and bit counters 0.
//  - All outputs registered. Reset asserted mid-frame aborts it: tx returns to 1 immediately.
//  - FSM: IDLE -> FETCH -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE | FETCH.
//  - IDLE: if enable && !fifo_empty -> FETCH.
//  - FETCH (1 cycle): fifo_rd_en=1. Asserted only here, and only when fifo_empty was 0 on entry.
//  - LOAD (1 cycle): capture fifo_data into shift reg; parity = ^fifo_data. -> START.
//  - START: tx=0 for CLK_DIV cycles.
//  - DATA: tx=shift[0]; shift right on each bit tick; DATA_WIDTH bit periods.
//  - PARITY: only if PARITY_EN; tx = even-parity bit, 1 period.
//  - STOP: tx=1 for STOP_BITS*CLK_DIV cycles.
//  - End of STOP: frame_done=1; if enable && !fifo_empty -> FETCH, else -> IDLE.
//  - Baud counter: width $clog2(CLK_DIV), loads CLK_DIV-1 at each bit start, tick at 0.
//  - Bit counter: width $clog2(DATA_WIDTH+1), counts data bits.
//  - Timing: fifo_rd_en high in cycle T; tx falls at cycle T+2.
//  - Frame = (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLK_DIV cycles.
//  - Back-to-back frames: exactly 2 extra idle-high cycles (FETCH, LOAD) between stop and next start.
//  - enable dropped mid-frame: current frame completes unchanged; no further fetch.
//  - fifo_empty rising mid-frame: no effect until the next fetch decision.
//  - Never pops an empty FIFO; never drops or duplicates a word.
// STRUCTURE
//  - Include fifo_uart_defs.vh: localparam state encodings (IDLE..STOP, 3-bit) and parity polarity.
//  - Sub-module baud_tick_gen (CLK_DIV): clear input, 1-cycle tick output; reused by the future RX side.
//  - Remainder is a single FSM + shift register in this file.
// TESTING (CLK_DIV=4, DATA_WIDTH=8 unless noted)
//  1. Reset, FIFO empty, enable=1 for 100 cycles -> tx=1, fifo_rd_en never 1, busy=0.
//  2. Push 0xA5, enable -> one rd_en pulse; tx 4-cycle periods: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first, stop);
//     frame_done once; 40 cycles from start bit to end of stop.
//  3. Push 0x00,0xFF,0x3C back-to-back -> 3 frames, 2-cycle idle gaps, 3 rd_en pulses, FIFO ends empty.
//  4. PARITY_EN=1, STOP_BITS=2, send 0x07 -> parity bit 1, then two stop periods; 0x03 -> parity 0.
//  5. Two words queued, enable dropped mid-DATA of frame 1 -> frame 1 completes, word 2 not popped;
//     re-enable -> word 2 sent.
//  6. rst_n low mid-DATA -> tx=1, busy=0 same cycle; after release, resumes with the next queued word.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM state encoding and parity polarity.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } tx_state_t;

    // 0 selects even parity: the parity bit makes the total count of ones even.
    localparam logic PARITY_ODD = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer: reloads CLK_DIV-1 on clear or after reaching zero, ticks while at zero.
module baud_tick_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || count == '0) begin
            count <= RELOAD;
        end else begin
            count <= count - 1'b1;
        end
    end

    // pre_tick flags the cycle before tick so callers can register an end-of-period pulse.
    assign tick     = !clear && (count == '0);
    assign pre_tick = !clear && (count == CW'(1));

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a registered-read sync FIFO and serialises each as a UART frame.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 16,
    parameter int PARITY_EN  = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  par;
    logic [BW-1:0]         bit_cnt;
    logic                  stop_cnt;
    logic                  tick;
    logic                  pre_tick;
    logic                  fetch_ok;

    assign fetch_ok   = enable && !fifo_empty;
    assign shift_next = shift >> 1;

    // Clearing during LOAD makes the start bit last exactly CLK_DIV cycles.
    baud_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == ST_LOAD),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            shift      <= '0;
            par        <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fetch_ok) begin
                        state      <= ST_FETCH;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    shift <= fifo_data;
                    par   <= (^fifo_data) ^ PARITY_ODD;
                    tx    <= 1'b0;
                    state <= ST_START;
                end
                ST_START: begin
                    if (tick) begin
                        state   <= ST_DATA;
                        tx      <= shift[0];
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift   <= shift_next;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                state <= ST_PARITY;
                                tx    <= par;
                            end else begin
                                state    <= ST_STOP;
                                tx       <= 1'b1;
                                stop_cnt <= (STOP_BITS == 2);
                            end
                        end else begin
                            tx <= shift_next[0];
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state    <= ST_STOP;
                        tx       <= 1'b1;
                        stop_cnt <= (STOP_BITS == 2);
                    end
                end
                ST_STOP: begin
                    // stop_cnt counts extra stop periods still owed after the current one.
                    if (pre_tick && !stop_cnt) begin
                        frame_done <= 1'b1;
                    end
                    if (tick) begin
                        if (stop_cnt) begin
                            stop_cnt <= 1'b0;
                        end else if (fetch_ok) begin
                            state      <= ST_FETCH;
                            fifo_rd_en <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: an 8N1 and an 8E2 instance, each fed by a modelled FIFO and checked cycle by cycle.
module tb_fifo_uart_tx;

    localparam int CLK_DIV = 4;
    localparam int DW      = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    [2];
    logic       empty [2];
    logic       rd    [2];
    logic       tx    [2];
    logic       busy  [2];
    logic       done  [2];
    logic [7:0] fdata [2];

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [2][64];
    int  head [2], tail [2], pushed [2], popped [2], framed [2], aborted [2];
    int  rd_seen [2], done_seen [2];
    int  lead [2], idx [2];
    bit  act [2], pend [2], m_busy [2], m_done [2];
    logic [7:0] word [2], cur [2];
    logic [15:0] cap0;
    logic [7:0]  plog;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLK_DIV(CLK_DIV), .PARITY_EN(0), .STOP_BITS(1)) dut_n1 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .fifo_empty(empty[0]), .fifo_rd_en(rd[0]),
        .fifo_data(fdata[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(done[0]));

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLK_DIV(CLK_DIV), .PARITY_EN(1), .STOP_BITS(2)) dut_e2 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .fifo_empty(empty[1]), .fifo_rd_en(rd[1]),
        .fifo_data(fdata[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(done[1]));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int flen(input int d);
        return (1 + DW + d + (d + 1)) * CLK_DIV;
    endfunction

    // Line level for cycle i of a frame: start, LSB-first data, even parity (instance 1), stop.
    function automatic logic exp_bit(input int d, input logic [7:0] w, input int i);
        int b;
        b = i / CLK_DIV;
        if (b == 0) return 1'b0;
        if (b <= DW) return w[b-1];
        if (d == 1 && b == DW + 1) return ^w;
        return 1'b1;
    endfunction

    function automatic int qcount(input int d);
        return tail[d] - head[d];
    endfunction

    task automatic push(input int d, input logic [7:0] w);
        mem[d][tail[d] % 64] = w;
        tail[d]++;
        pushed[d]++;
        empty[d] = 1'b0;
    endtask

    task automatic step();
        bit   go [2];
        logic etx;
        for (int d = 0; d < 2; d++)
            go[d] = rst_n && (!m_busy[d] || m_done[d]) && en[d] && !empty[d];
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (pend[d]) begin
                fdata[d] = mem[d][head[d] % 64];
                word[d]  = fdata[d];
                head[d]++;
                popped[d]++;
                pend[d] = 1'b0;
            end
            if (lead[d] > 0) begin
                lead[d]--;
                if (lead[d] == 0) begin
                    act[d] = 1'b1;
                    idx[d] = 0;
                    cur[d] = word[d];
                end
            end else if (act[d]) begin
                idx[d]++;
                if (idx[d] == flen(d)) begin
                    act[d] = 1'b0;
                    framed[d]++;
                end
            end
            if (go[d]) begin
                lead[d] = 2;
                pend[d] = 1'b1;
            end
            m_busy[d] = act[d] || (lead[d] > 0);
            m_done[d] = act[d] && (idx[d] == flen(d) - 1);
            etx = act[d] ? exp_bit(d, cur[d], idx[d]) : 1'b1;
            check($sformatf("d%0d.rd_busy_done_tx", d),
                  {rd[d], busy[d], done[d], tx[d]}, {go[d], m_busy[d], m_done[d], etx});
            rd_seen[d]   += int'(rd[d]);
            done_seen[d] += int'(done[d]);
            if (d == 0 && act[0] && idx[0] % CLK_DIV == 2) cap0 = {cap0[14:0], tx[0]};
            if (d == 1 && act[1] && idx[1] == (DW + 1) * CLK_DIV + 2) plog = {plog[6:0], tx[1]};
            empty[d] = (qcount(d) == 0);
        end
    endtask

    task automatic wait_idle(input bit need_empty, input int limit);
        int n;
        bit idle;
        n = 0;
        idle = 1'b0;
        while (n < limit && !idle) begin
            idle = 1'b1;
            for (int d = 0; d < 2; d++)
                if (act[d] || lead[d] > 0 || pend[d] || (need_empty && qcount(d) != 0)) idle = 1'b0;
            if (!idle) begin
                step();
                n++;
            end
        end
        check("wait_idle.in_time", int'(idle), 1);
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d.reset_outs", d), {rd[d], busy[d], done[d], tx[d]}, 4'b0001);
            if (act[d] || lead[d] > 0) aborted[d]++;
            act[d] = 1'b0;
            lead[d] = 0;
            m_busy[d] = 1'b0;
            m_done[d] = 1'b0;
        end
        for (int i = 0; i < hold; i++) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int r0, d0;
        bit hit;
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b0; empty[d] = 1'b1; fdata[d] = '0;
            head[d] = 0; tail[d] = 0; pushed[d] = 0; popped[d] = 0; framed[d] = 0; aborted[d] = 0;
            rd_seen[d] = 0; done_seen[d] = 0; lead[d] = 0; idx[d] = 0;
            act[d] = 1'b0; pend[d] = 1'b0; m_busy[d] = 1'b0; m_done[d] = 1'b0;
            word[d] = '0; cur[d] = '0;
        end
        cap0 = '0;
        plog = '0;
        #2;
        do_reset(3);

        // Empty FIFO with enable held high: no pops, line idle.
        en[0] = 1'b1; en[1] = 1'b1;
        for (int i = 0; i < 100; i++) step();
        check("t1.no_pop_n1", rd_seen[0], 0);
        check("t1.no_pop_e2", rd_seen[1], 0);

        // Single 0xA5 frame.
        cap0 = '0;
        r0 = rd_seen[0];
        d0 = done_seen[0];
        push(0, 8'hA5); push(1, 8'hA5);
        wait_idle(1'b1, 200);
        check("t2.rd_pulses", rd_seen[0] - r0, 1);
        check("t2.frame_done", done_seen[0] - d0, 1);
        check("t2.waveform", int'(cap0[9:0]), int'(10'b0101001011));

        // Back-to-back frames.
        r0 = rd_seen[0];
        d0 = framed[0];
        push(0, 8'h00); push(0, 8'hFF); push(0, 8'h3C);
        push(1, 8'h00); push(1, 8'hFF); push(1, 8'h3C);
        wait_idle(1'b1, 400);
        check("t3.rd_pulses", rd_seen[0] - r0, 3);
        check("t3.frames", framed[0] - d0, 3);
        check("t3.fifo_empty", int'(empty[0]), 1);

        // Parity and two stop bits on the 8E2 instance.
        plog = '0;
        push(0, 8'h07); push(1, 8'h07); push(0, 8'h03); push(1, 8'h03);
        wait_idle(1'b1, 400);
        check("t4.parity_bits", int'(plog[1:0]), 2);

        // Enable dropped in the middle of the first frame.
        r0 = rd_seen[0];
        push(0, 8'h5A); push(1, 8'h5A); push(0, 8'hC3); push(1, 8'hC3);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            step();
            hit = act[0] && idx[0] == 20;
        end
        check("t5.reached_data", int'(hit), 1);
        en[0] = 1'b0; en[1] = 1'b0;
        wait_idle(1'b0, 200);
        for (int i = 0; i < 20; i++) step();
        check("t5.one_pop", rd_seen[0] - r0, 1);
        check("t5.word_kept", qcount(1), 1);
        en[0] = 1'b1; en[1] = 1'b1;
        wait_idle(1'b1, 200);
        check("t5.drained", rd_seen[0] - r0, 2);

        // Reset in the middle of a frame.
        push(0, 8'h81); push(1, 8'h81); push(0, 8'h7E); push(1, 8'h7E);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            step();
            hit = act[0] && idx[0] == 20;
        end
        check("t6.reached_data", int'(hit), 1);
        do_reset(2);
        wait_idle(1'b1, 200);
        check("t6.aborted", aborted[0], 1);

        // Random traffic with enable toggling.
        for (int i = 0; i < 1500; i++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(11) == 0 && qcount(d) < 50) push(d, 8'($urandom));
                if ($urandom_range(39) == 0) en[d] = ~en[d];
            end
        end
        en[0] = 1'b1; en[1] = 1'b1;
        wait_idle(1'b1, 6000);

        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d.no_loss", d), framed[d] + aborted[d], pushed[d]);
            check($sformatf("d%0d.pops", d), rd_seen[d], popped[d]);
            check($sformatf("d%0d.pops_vs_pushes", d), popped[d], pushed[d]);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
